// File: rtl/axi_wdata_packer_gen_if.sv
// ---------------------------------------------------------------------------
// axi_wdata_packer_gen_if
// Bundles the three sides of the write-data packer into one interface:
//   - burst descriptor FIFO head (b_empty, burst_addr/len/size) and b_pop
//   - packet data FIFO head (data_empty, wdata_pckt = {data, byte_en}) and
//     data_fifo_pop
//   - AXI4 W channel (axi_wvalid/wdata/wstrb/wlast, rdy_from_slv = WREADY)
//   - burst_err, a one-cycle malformed-descriptor pulse
// Modport master is the packer's view; modport slave is the surrounding
// FIFOs and AXI sink.
// ---------------------------------------------------------------------------
interface axi_wdata_packer_gen_if #(
    parameter int AXI_DW = 64,
    parameter int PKT_DW = 32,
    parameter int LEN_W  = 8
);
    logic                       b_empty;
    logic [31:0]                burst_addr;
    logic [LEN_W-1:0]           burst_len;
    logic [2:0]                 burst_size;
    logic                       b_pop;
    logic                       data_empty;
    logic [PKT_DW+PKT_DW/8-1:0] wdata_pckt;
    logic                       data_fifo_pop;
    logic                       rdy_from_slv;
    logic                       axi_wvalid;
    logic [AXI_DW-1:0]          axi_wdata;
    logic [AXI_DW/8-1:0]        axi_wstrb;
    logic                       axi_wlast;
    logic                       burst_err;

    modport master (
        input  b_empty, burst_addr, burst_len, burst_size,
        input  data_empty, wdata_pckt, rdy_from_slv,
        output b_pop, data_fifo_pop,
        output axi_wvalid, axi_wdata, axi_wstrb, axi_wlast, burst_err
    );

    modport slave (
        output b_empty, burst_addr, burst_len, burst_size,
        output data_empty, wdata_pckt, rdy_from_slv,
        input  b_pop, data_fifo_pop,
        input  axi_wvalid, axi_wdata, axi_wstrb, axi_wlast, burst_err
    );
endinterface

// File: rtl/axi_wdata_packer_gen.sv
// ---------------------------------------------------------------------------
// axi_wdata_packer_gen
// Turns one burst descriptor plus a stream of {data, byte_en} packets into
// AXI4 W beats of width AXI_DW. Full-width sizes pack several packets per
// beat; narrow sizes land on their address-derived byte lanes.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset (abandons any burst, pops nothing)
//   bus  - master modport of axi_wdata_packer_gen_if (descriptor FIFO,
//          packet FIFO, AXI W channel, burst_err)
// Flow: IDLE pops a descriptor, FILL pops PPB packets into a staging
// register, SEND presents the beat until WREADY, then FILL or IDLE.
// ---------------------------------------------------------------------------
module axi_wdata_packer_gen #(
    parameter int AXI_DW = 64,
    parameter int PKT_DW = 32,
    parameter int LEN_W  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    axi_wdata_packer_gen_if.master bus
);
    localparam int AB    = AXI_DW / 8;
    localparam int PB    = PKT_DW / 8;
    localparam int AB_LG = $clog2(AB);
    localparam int PB_LG = $clog2(PB);
    localparam int NLANE = AB / PB;
    localparam int PC_W  = $clog2(NLANE) + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, SEND = 2'd2} state_t;

    state_t              state_q, state_d;
    logic [31:0]         addr_q, addr_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [2:0]          size_q, size_d;
    logic [LEN_W:0]      beat_cnt_q, beat_cnt_d;
    logic [PC_W-1:0]     pkt_cnt_q, pkt_cnt_d;
    logic [AXI_DW-1:0]   stage_data_q, stage_data_d;
    logic [AB-1:0]       stage_strb_q, stage_strb_d;
    logic [AXI_DW-1:0]   wdata_q, wdata_d;
    logic [AB-1:0]       wstrb_q, wstrb_d;
    logic                wvalid_q, wvalid_d;
    logic                wlast_q, wlast_d;
    logic                err_q, err_d;
    logic                b_pop_c, pop_c;

    // Descriptor sanitising: clamp size to the bus width, then align the
    // address down to the (clamped) beat size.
    logic        desc_clamp, desc_misalign;
    logic [2:0]  desc_size;
    logic [31:0] desc_amask;
    assign desc_clamp    = {29'd0, bus.burst_size} > 32'(AB_LG);
    assign desc_size     = desc_clamp ? 3'(AB_LG) : bus.burst_size;
    assign desc_amask    = (32'd1 << desc_size) - 32'd1;
    assign desc_misalign = (bus.burst_addr & desc_amask) != 32'd0;

    // Placement of the packet at the FIFO head within the current beat.
    logic [31:0]       sz_w, bb_w, lane_w;
    logic [PC_W-1:0]   ppb_m1;
    logic [PB-1:0]     pkt_be, narrow_mask;
    logic [PKT_DW-1:0] pkt_data;
    logic [AXI_DW-1:0] pkt_data_sh;
    logic [AB-1:0]     pkt_strb_sh;

    assign sz_w   = {29'd0, size_q};
    assign bb_w   = 32'd1 << size_q;
    // Packets per beat minus one: 0 for sizes at or below the packet width.
    assign ppb_m1 = (sz_w > 32'(PB_LG)) ?
                    PC_W'((32'd1 << (sz_w - 32'(PB_LG))) - 32'd1) : '0;
    // Packet-sized lane index: address lane rounded to a packet, plus k.
    assign lane_w = ((addr_q >> PB_LG) % 32'(NLANE)) + 32'(pkt_cnt_q);
    // Narrow beats only strobe the BB bytes starting at addr mod PB.
    assign narrow_mask = (bb_w < 32'(PB)) ?
                         PB'(((32'd1 << bb_w) - 32'd1) << (addr_q % 32'(PB))) : '1;
    assign pkt_be      = bus.wdata_pckt[PB-1:0];
    assign pkt_data    = bus.wdata_pckt[PB +: PKT_DW];
    assign pkt_data_sh = AXI_DW'(pkt_data) << (lane_w * 32'(PKT_DW));
    assign pkt_strb_sh = AB'(pkt_be & narrow_mask) << (lane_w * 32'(PB));

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        len_d        = len_q;
        size_d       = size_q;
        beat_cnt_d   = beat_cnt_q;
        pkt_cnt_d    = pkt_cnt_q;
        stage_data_d = stage_data_q;
        stage_strb_d = stage_strb_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        wvalid_d     = wvalid_q;
        wlast_d      = wlast_q;
        err_d        = 1'b0;
        b_pop_c      = 1'b0;
        pop_c        = 1'b0;
        case (state_q)
            IDLE: begin
                if (!bus.b_empty) begin
                    b_pop_c    = 1'b1;
                    addr_d     = bus.burst_addr & ~desc_amask;
                    len_d      = bus.burst_len;
                    size_d     = desc_size;
                    beat_cnt_d = '0;
                    pkt_cnt_d  = '0;
                    err_d      = desc_clamp | desc_misalign;
                    state_d    = FILL;
                end
            end
            FILL: begin
                if (!bus.data_empty) begin
                    pop_c = 1'b1;
                    if (pkt_cnt_q == ppb_m1) begin
                        // Last packet goes straight to the output registers
                        // together with whatever was staged before it.
                        wdata_d      = stage_data_q | pkt_data_sh;
                        wstrb_d      = stage_strb_q | pkt_strb_sh;
                        wvalid_d     = 1'b1;
                        wlast_d      = (beat_cnt_q == {1'b0, len_q});
                        stage_data_d = '0;
                        stage_strb_d = '0;
                        pkt_cnt_d    = '0;
                        state_d      = SEND;
                    end else begin
                        stage_data_d = stage_data_q | pkt_data_sh;
                        stage_strb_d = stage_strb_q | pkt_strb_sh;
                        pkt_cnt_d    = pkt_cnt_q + 1'b1;
                    end
                end
            end
            SEND: begin
                if (bus.rdy_from_slv) begin
                    wvalid_d   = 1'b0;
                    wdata_d    = '0;
                    wstrb_d    = '0;
                    wlast_d    = 1'b0;
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    addr_d     = addr_q + bb_w;
                    state_d    = wlast_q ? IDLE : FILL;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            len_q        <= '0;
            size_q       <= '0;
            beat_cnt_q   <= '0;
            pkt_cnt_q    <= '0;
            stage_data_q <= '0;
            stage_strb_q <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            wvalid_q     <= 1'b0;
            wlast_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            size_q       <= size_d;
            beat_cnt_q   <= beat_cnt_d;
            pkt_cnt_q    <= pkt_cnt_d;
            stage_data_q <= stage_data_d;
            stage_strb_q <= stage_strb_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            wvalid_q     <= wvalid_d;
            wlast_q      <= wlast_d;
            err_q        <= err_d;
        end
    end

    // Pops are combinational; gate with rst so nothing is consumed in reset.
    assign bus.b_pop         = b_pop_c & ~rst;
    assign bus.data_fifo_pop = pop_c & ~rst;
    assign bus.axi_wvalid    = wvalid_q;
    assign bus.axi_wdata     = wdata_q;
    assign bus.axi_wstrb     = wstrb_q;
    assign bus.axi_wlast     = wlast_q;
    assign bus.burst_err     = err_q;
endmodule

// File: tb/tb_axi_wdata_packer_gen.sv
module tb_axi_wdata_packer_gen;
    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
    } desc_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi_wdata_packer_gen_if #(.AXI_DW(64), .PKT_DW(32), .LEN_W(8)) bus ();

    axi_wdata_packer_gen #(.AXI_DW(64), .PKT_DW(32), .LEN_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    desc_t       bq[$];
    logic [35:0] pq[$];
    beat_t       exp_q[$];

    int checks  = 0;
    int errors  = 0;
    int hs_cnt  = 0;
    int pop_cnt = 0;
    int bpop_cnt = 0;
    int err_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got 0x%0h want 0x%0h at %0t", nm, act, req, $time);
        end else begin
            $display("ok   %s = 0x%0h", nm, act);
        end
    endtask

    task automatic push_desc(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s);
        desc_t d;
        d.addr = a; d.len = l; d.size = s;
        bq.push_back(d);
    endtask

    task automatic push_pkt(input logic [31:0] d, input logic [3:0] be);
        pq.push_back({d, be});
    endtask

    task automatic push_beat(input logic [63:0] d, input logic [7:0] s, input logic l);
        beat_t b;
        b.data = d; b.strb = s; b.last = l;
        exp_q.push_back(b);
    endtask

    task automatic wait_hs(input int target);
        int n = 0;
        do begin @(posedge clk); #2; n++; end while (hs_cnt < target && n < 300);
        if (hs_cnt < target) begin
            checks++; errors++;
            $display("FAIL wait_hs timeout got %0d want %0d", hs_cnt, target);
        end
    endtask

    task automatic wait_pop(input int target);
        int n = 0;
        do begin @(posedge clk); #2; n++; end while (pop_cnt < target && n < 300);
        if (pop_cnt < target) begin
            checks++; errors++;
            $display("FAIL wait_pop timeout got %0d want %0d", pop_cnt, target);
        end
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_wvalid"}, 64'(bus.axi_wvalid), 64'd0);
        chk({tag, "_wdata"},  bus.axi_wdata, 64'd0);
        chk({tag, "_wstrb"},  64'(bus.axi_wstrb), 64'd0);
        chk({tag, "_wlast"},  64'(bus.axi_wlast), 64'd0);
        chk({tag, "_b_pop"},  64'(bus.b_pop), 64'd0);
        chk({tag, "_dpop"},   64'(bus.data_fifo_pop), 64'd0);
        chk({tag, "_err"},    64'(bus.burst_err), 64'd0);
    endtask

    // FIFO models: consume heads on pops, then present the new heads.
    always @(posedge clk) begin
        if (!rst) begin
            if (bus.b_pop) begin
                bpop_cnt++;
                if (bq.size() > 0) void'(bq.pop_front());
            end
            if (bus.data_fifo_pop) begin
                pop_cnt++;
                if (pq.size() > 0) void'(pq.pop_front());
            end
        end
        #1;
        bus.b_empty = (bq.size() == 0);
        if (bq.size() > 0) begin
            bus.burst_addr = bq[0].addr;
            bus.burst_len  = bq[0].len;
            bus.burst_size = bq[0].size;
        end
        bus.data_empty = (pq.size() == 0);
        bus.wdata_pckt = (pq.size() > 0) ? pq[0] : 36'd0;
    end

    // Monitor / scoreboard.
    logic        prev_stall = 1'b0;
    logic [63:0] sv_data;
    logic [7:0]  sv_strb;
    logic        sv_last;
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_wvalid", 64'(bus.axi_wvalid), 64'd1);
                chk("hold_wdata", bus.axi_wdata, sv_data);
                chk("hold_wstrb", 64'(bus.axi_wstrb), 64'(sv_strb));
                chk("hold_wlast", 64'(bus.axi_wlast), 64'(sv_last));
            end
            if (bus.axi_wvalid) chk("no_pop_in_send", 64'(bus.data_fifo_pop), 64'd0);
            if (bus.burst_err) err_cnt++;
            if (bus.axi_wvalid && bus.rdy_from_slv) begin
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_beat got wdata 0x%0h wstrb 0x%0h want none",
                             bus.axi_wdata, bus.axi_wstrb);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_wdata", bus.axi_wdata, e.data);
                    chk("beat_wstrb", 64'(bus.axi_wstrb), 64'(e.strb));
                    chk("beat_wlast", 64'(bus.axi_wlast), 64'(e.last));
                end
            end
            prev_stall = bus.axi_wvalid && !bus.rdy_from_slv;
            sv_data = bus.axi_wdata;
            sv_strb = bus.axi_wstrb;
            sv_last = bus.axi_wlast;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int h0, p0, b0, e0;
        bus.b_empty = 1'b1;
        bus.burst_addr = '0;
        bus.burst_len = '0;
        bus.burst_size = '0;
        bus.data_empty = 1'b1;
        bus.wdata_pckt = '0;
        bus.rdy_from_slv = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        chk_outputs_zero("reset");
        @(posedge clk); #2;
        rst = 1'b0;

        // Narrow 32-bit beats on a 64-bit bus, with a 3-cycle WREADY stall.
        h0 = hs_cnt; p0 = pop_cnt; b0 = bpop_cnt; e0 = err_cnt;
        push_desc(32'hDEAD0004, 8'd2, 3'd2);
        push_pkt(32'h11111111, 4'hF);
        push_pkt(32'h22222222, 4'hF);
        push_pkt(32'h33333333, 4'hF);
        push_beat(64'h11111111_00000000, 8'hF0, 1'b0);
        push_beat(64'h00000000_22222222, 8'h0F, 1'b0);
        push_beat(64'h33333333_00000000, 8'hF0, 1'b1);
        wait_hs(h0 + 1);
        bus.rdy_from_slv = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        bus.rdy_from_slv = 1'b1;
        wait_hs(h0 + 3);
        settle(3);
        chk("s1_pops", 64'(pop_cnt - p0), 64'd3);
        chk("s1_bpops", 64'(bpop_cnt - b0), 64'd1);
        chk("s1_err", 64'(err_cnt - e0), 64'd0);

        // Full-width packing, with the data FIFO running dry mid-FILL.
        h0 = hs_cnt; p0 = pop_cnt; e0 = err_cnt;
        push_desc(32'h00001000, 8'd1, 3'd3);
        push_pkt(32'h11111111, 4'hF);
        push_beat(64'h22222222_11111111, 8'h3F, 1'b0);
        push_beat(64'hBBBBBBBB_AAAAAAAA, 8'hFF, 1'b1);
        wait_pop(p0 + 1);
        repeat (4) begin
            @(negedge clk);
            chk("s2_empty_no_pop", 64'(bus.data_fifo_pop), 64'd0);
            chk("s2_empty_no_valid", 64'(bus.axi_wvalid), 64'd0);
        end
        @(posedge clk); #2;
        push_pkt(32'h22222222, 4'h3);
        push_pkt(32'hAAAAAAAA, 4'hF);
        push_pkt(32'hBBBBBBBB, 4'hF);
        wait_hs(h0 + 2);
        settle(3);
        chk("s2_pops", 64'(pop_cnt - p0), 64'd4);
        chk("s2_err", 64'(err_cnt - e0), 64'd0);

        // Byte-size beats on their address lanes.
        h0 = hs_cnt; e0 = err_cnt;
        push_desc(32'h00001001, 8'd1, 3'd0);
        push_pkt(32'h0000AB00, 4'h2);
        push_pkt(32'h00CD0000, 4'hF);
        push_beat(64'h00000000_0000AB00, 8'h02, 1'b0);
        push_beat(64'h00000000_00CD0000, 8'h04, 1'b1);
        wait_hs(h0 + 2);
        settle(3);
        chk("s3_err", 64'(err_cnt - e0), 64'd0);

        // Misaligned word address: aligned down to 0x2000.
        h0 = hs_cnt; e0 = err_cnt;
        push_desc(32'h00002002, 8'd1, 3'd2);
        push_pkt(32'h44444444, 4'hF);
        push_pkt(32'h45454545, 4'hF);
        push_beat(64'h00000000_44444444, 8'h0F, 1'b0);
        push_beat(64'h45454545_00000000, 8'hF0, 1'b1);
        wait_hs(h0 + 2);
        settle(3);
        chk("s4a_err", 64'(err_cnt - e0), 64'd1);

        // Misaligned halfword: 0x3003 -> 0x3002, strobes bytes 2..3.
        h0 = hs_cnt; e0 = err_cnt;
        push_desc(32'h00003003, 8'd0, 3'd1);
        push_pkt(32'h12345678, 4'hF);
        push_beat(64'h00000000_12345678, 8'h0C, 1'b1);
        wait_hs(h0 + 1);
        settle(3);
        chk("s4b_err", 64'(err_cnt - e0), 64'd1);

        // Oversized beat: size 4 clamps to 3.
        h0 = hs_cnt; e0 = err_cnt; p0 = pop_cnt;
        push_desc(32'h00004000, 8'd0, 3'd4);
        push_pkt(32'h55555555, 4'hF);
        push_pkt(32'h66666666, 4'hF);
        push_beat(64'h66666666_55555555, 8'hFF, 1'b1);
        wait_hs(h0 + 1);
        settle(3);
        chk("s5_err", 64'(err_cnt - e0), 64'd1);
        chk("s5_pops", 64'(pop_cnt - p0), 64'd2);

        // Reset in the middle of a 3-beat burst.
        h0 = hs_cnt;
        push_desc(32'h00005000, 8'd2, 3'd2);
        push_pkt(32'h77777777, 4'hF);
        push_pkt(32'h77777777, 4'hF);
        push_pkt(32'h77777777, 4'hF);
        push_beat(64'h00000000_77777777, 8'h0F, 1'b0);
        wait_hs(h0 + 1);
        bus.rdy_from_slv = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("s6_beat1_valid", 64'(bus.axi_wvalid), 64'd1);
        rst = 1'b1;
        #1;
        chk_outputs_zero("s6_rst");
        bq.delete();
        pq.delete();
        exp_q.delete();
        bus.rdy_from_slv = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;

        // Clean burst after reset; wlast on beat1 shows beat count restarted.
        h0 = hs_cnt; p0 = pop_cnt; b0 = bpop_cnt; e0 = err_cnt;
        push_desc(32'h00006000, 8'd1, 3'd2);
        push_pkt(32'h88888888, 4'hF);
        push_pkt(32'h99999999, 4'hF);
        push_beat(64'h00000000_88888888, 8'h0F, 1'b0);
        push_beat(64'h99999999_00000000, 8'hF0, 1'b1);
        wait_hs(h0 + 2);
        settle(3);
        chk("s7_pops", 64'(pop_cnt - p0), 64'd2);
        chk("s7_bpops", 64'(bpop_cnt - b0), 64'd1);
        chk("s7_err", 64'(err_cnt - e0), 64'd0);
        chk("s7_idle_wvalid", 64'(bus.axi_wvalid), 64'd0);
        chk("exp_q_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi_wdata_packer_gen.md
Name: axi_wdata_packer_gen

Overview:
- Parametrised successor to the single-width AXI write-data packer. Consumes one burst descriptor (addr, len, size) and a stream of {data, byte-enable} packets from show-ahead FIFOs.
- Drives an AXI4 W channel of width AXI_DW, which may be wider than the packet width PKT_DW.
- Packs several packets per beat for full-width sizes, and places narrow transfers on their address-derived byte lanes.
- Sits between the peripheral-side burst/data FIFOs and the AXI master write-data port.

Parameters:
- AXI_DW, 64, AXI W data width in bits. Power of 2, >= PKT_DW.
- PKT_DW, 32, peripheral packet data width in bits. Power of 2, >= 8.
- LEN_W, 8, width of the burst length field (beats-1).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- b_empty  in  1  burst FIFO empty.
- burst_addr  in  32  burst start address (FIFO head).
- burst_len  in  LEN_W  beats-1 (FIFO head).
- burst_size  in  3  log2(bytes per beat) (FIFO head).
- b_pop  out  1  burst FIFO pop.
- data_empty  in  1  data FIFO empty.
- wdata_pckt  in  PKT_DW+PKT_DW/8  {data, byte_en}; byte_en is in the LSBs (FIFO head).
- data_fifo_pop  out  1  data FIFO pop.
- rdy_from_slv  in  1  AXI WREADY.
- axi_wvalid  out  1  AXI WVALID.
- axi_wdata  out  AXI_DW  AXI WDATA.
- axi_wstrb  out  AXI_DW/8  AXI WSTRB.
- axi_wlast  out  1  AXI WLAST.
- burst_err  out  1  one-cycle pulse: descriptor malformed.

Behaviour:
- Definitions: AB = AXI_DW/8; PB = PKT_DW/8; beat bytes BB = 2^size; packets per beat PPB = max(1, BB/PB).
- Reset (async, rst=1): FSM to IDLE. All outputs 0. Beat counter, address and packing registers cleared. An in-flight burst is abandoned and no FIFO is popped.
- Both FIFOs are show-ahead: head data is valid whenever empty=0. A pop consumes the head at the clock edge.
- IDLE: if !b_empty, assert b_pop (combinational, this cycle only), latch addr/len/size, go to FILL. Otherwise stay.
- Descriptor check at latch:
  - size > log2(AB): clamp size to log2(AB).
  - addr not aligned to 2^size (after clamp): align addr down.
  - Either condition asserts burst_err for one cycle (the cycle after b_pop). The burst still executes.
- FILL: data_fifo_pop = !data_empty (combinational). Each popped packet is written into the staging register.
  - Lane offset = (cur_addr mod AB) rounded down to a PB multiple, plus k*PB for the k-th packet of the beat.
  - Strobe bits = byte_en AND narrow mask. The narrow mask covers only bytes [cur_addr mod PB, +BB) when BB < PB; otherwise it is all ones.
  - Non-written lanes have data 0 and strobe 0.
  - After PPB pops, go to SEND. While data_empty=1, stall: no pop, no wvalid.
- SEND: the staged beat is in the output registers and axi_wvalid=1.
  - axi_wlast = (beat_cnt == len).
  - wvalid, wdata, wstrb and wlast hold stable until rdy_from_slv=1.
  - On handshake: beat_cnt++, cur_addr += BB (INCR only; no wrap of the 32-bit address). Go to FILL if it was not the last beat, otherwise IDLE.
  - Outputs drop to 0 the cycle after the handshake unless a new beat is already staged.
- Latency:
  - b_pop to first data_fifo_pop: 1 cycle.
  - Last pop of a beat to axi_wvalid: 1 cycle.
  - Throughput: one beat per PPB+1 cycles with no backpressure.
- Burst-to-burst gap: IDLE after the last handshake, with at least 1 idle cycle before the next b_pop.
- Simultaneous events:
  - b_empty is ignored outside IDLE.
  - data_fifo_pop is never asserted in SEND or IDLE.
  - rdy_from_slv while wvalid=0 has no effect.
- beat_cnt width is LEN_W+1, so a len of all-ones gives 2^LEN_W beats without overflow.

Test Plan:
- AXI_DW=64, PKT_DW=32, addr 0xDEAD0004, len=2, size=2, packets 0x11111111/F, 0x22222222/F, 0x33333333/F, rdy=1:
  - beat0 wdata 0x11111111_00000000, wstrb 0xF0.
  - beat1 wdata 0x00000000_22222222, wstrb 0x0F.
  - beat2 wdata 0x33333333_00000000, wstrb 0xF0, with wlast=1.
  - Exactly 3 pops and 1 b_pop.
- addr 0x1000, len=1, size=3, packets 0x11111111/F, 0x22222222/3, 0xAAAAAAAA/F, 0xBBBBBBBB/F:
  - beat0 wdata 0x22222222_11111111, wstrb 0x3F, wlast=0.
  - beat1 wstrb 0xFF, wlast=1.
- Size 0 at addr 0x1001, len=1, packet 0x0000AB00/2:
  - beat0 wstrb 0x02.
  - beat1 (addr 0x1002) with packet be F gives wstrb 0x04.
- Hold rdy_from_slv=0 for 3 cycles during beat1 of the first scenario: wvalid, wdata, wstrb and wlast are unchanged every cycle, and no data_fifo_pop occurs.
- Assert data_empty=1 for 4 cycles mid-FILL: no pop, no wvalid. Resumes correctly after data_empty drops.
- Misaligned addr 0x2002 with size=2: burst_err pulses once and beats use addr 0x2000.
- Size=4 with AXI_DW=64: burst_err pulses once and the burst runs as size=3.
- Assert rst during beat1 of a 3-beat burst: all outputs 0 immediately. The next burst runs cleanly with beat_cnt restarting at 0.
